execute_stage_mc: RTL and testbench
===================================

Name: execute_stage_mc

Overview:
- Parametrised, registered successor of the single-cycle MIPS execute stage.
- Adds a valid/ready handshake on both sides, an EX/MEM output register, and an iterative multiply/divide unit with HI/LO registers, so mult/div/mfhi/mflo execute in this stage.
- Sits between the ID/EX and MEM stages; stalls upstream while a mult/div is in flight or the output is blocked.

Parameters:
- WIDTH, 32, datapath width (≥8, even).
- REG_BITS, 5, register-index width.
- MULDIV_EN, 1, 0 removes the mult/div unit; funct 0x18–0x1B then execute as add.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream operation valid.
- in_ready  out  1  stage accepts an operation this cycle.
- read_data1  in  WIDTH  operand A.
- read_data2  in  WIDTH  operand B / store data.
- immediate  in  WIDTH  sign-extended immediate; [10:6] = shamt.
- funct  in  6  R-type function.
- alu_op  in  3  000 add, 001 sub, 010 R-type, 011 and, 100 or, 101 slt; 110/111 add.
- alu_src  in  1  1 selects immediate as operand B.
- reg_dst  in  1  1 selects rd, else rt.
- last_pc  in  WIDTH  PC+4 of the instruction.
- rt, rd  in  REG_BITS  destination candidates.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  downstream accepts.
- alu_result  out  WIDTH  registered result.
- zero  out  1  registered (alu_result == 0).
- branch_target  out  WIDTH  registered last_pc + (immediate << 2), truncated to WIDTH.
- store_data  out  WIDTH  registered read_data2.
- dest_reg  out  REG_BITS  registered rt/rd.
- hi, lo  out  WIDTH  architectural HI/LO.
- busy  out  1  mult/div in progress.

Behaviour:
- Reset (async, rst_n low): state IDLE; out_valid=0; alu_result, branch_target, store_data, hi, lo=0; dest_reg=0; zero=1; busy=0. Reset mid-mult/div aborts it; HI/LO are cleared.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - An operation is accepted on in_valid && in_ready.
  - Output fields are stable while out_valid && !out_ready.
  - Output retires on out_valid && out_ready.
- Single-cycle ops:
  - Result is registered at the accepting edge; out_valid=1 the next cycle (latency 1).
  - Accept and retire in the same cycle give back-to-back throughput of 1/cycle.
- R-type funct:
  - 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor.
  - 0x2A slt (signed), 0x2B sltu.
  - 0x00 sll, 0x02 srl, 0x03 sra, all by shamt.
  - 0x10 mfhi, 0x12 mflo, returning the HI/LO value current at acceptance.
  - Any other funct gives add.
- Arithmetic: wrap modulo 2^WIDTH, no overflow trap. slt/sltu return 1 or 0 zero-extended.
- Mult/div FSM: IDLE → MULDIV → IDLE.
  - Accepting funct 0x18 mult, 0x19 multu, 0x1A div or 0x1B divu enters MULDIV, with counter=WIDTH and busy=1.
  - One shift-add (mult) or restoring-subtract (div) step per cycle.
  - After WIDTH steps the stage writes HI/LO and sets out_valid=1 with alu_result=0, returning to IDLE. Latency is WIDTH+1 cycles from acceptance.
  - Signed variants work on magnitudes and then fix the sign: quotient truncates toward zero, remainder takes the dividend's sign.
  - mult: {hi,lo} = full 2·WIDTH product.
  - div: lo = quotient, hi = remainder.
  - Divide by zero: lo = all-ones, hi = dividend; no exception.
- mfhi/mflo accepted immediately after a mult/div returns the new HI/LO, since acceptance is blocked until completion.
- branch_target, store_data and dest_reg are captured for every op, including mult/div.

Test Plan:
- Reset during MULDIV at cycle 5 → busy=0, out_valid=0, hi=lo=0, in_ready=1 after rst_n returns high.
- alu_op=010, funct=0x22, A=5, B=5 → next cycle alu_result=0, zero=1, out_valid=1. Then alu_op=000, alu_src=1, A=0x1000, imm=0xFFFFFFFC → alu_result=0x00000FFC.
- Back-to-back: 4 adds with out_ready=1 → 4 results on consecutive cycles. Drop out_ready for 3 cycles → output held, in_ready=0, no op lost.
- mult A=0xFFFFFFFE (−2), B=3 → out_valid exactly 33 cycles after acceptance, hi=0xFFFFFFFF, lo=0xFFFFFFFA; in_ready=0 throughout. Then mflo → 0xFFFFFFFA.
- div A=−7, B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu A=7, B=0 → lo=0xFFFFFFFF, hi=7.
- funct=0x03, shamt=4, B=0x80000000 → 0xF8000000. Then sll shamt=31, B=1 → 0x80000000. last_pc=0x100, imm=−1 → branch_target=0xFC. reg_dst=1 → dest_reg=rd.

Source files
------------

// File: rtl/execute_stage_mc.sv
// Registered MIPS execute stage: valid/ready handshake on both sides, EX/MEM
// output register, and an iterative multiply/divide unit that owns HI/LO.
module execute_stage_mc #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned REG_BITS  = 5,
    parameter bit          MULDIV_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    read_data1,
    input  logic [WIDTH-1:0]    read_data2,
    input  logic [WIDTH-1:0]    immediate,
    input  logic [5:0]          funct,
    input  logic [2:0]          alu_op,
    input  logic                alu_src,
    input  logic                reg_dst,
    input  logic [WIDTH-1:0]    last_pc,
    input  logic [REG_BITS-1:0] rt,
    input  logic [REG_BITS-1:0] rd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    alu_result,
    output logic                zero,
    output logic [WIDTH-1:0]    branch_target,
    output logic [WIDTH-1:0]    store_data,
    output logic [REG_BITS-1:0] dest_reg,
    output logic [WIDTH-1:0]    hi,
    output logic [WIDTH-1:0]    lo,
    output logic                busy
);
    localparam int unsigned DW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_MULDIV = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]       acc_q, acc_d;
    logic [WIDTH-1:0]    opnd_q, opnd_d;
    logic                is_div_q, is_div_d;
    logic                neg_lo_q, neg_lo_d;
    logic                neg_hi_q, neg_hi_d;
    logic                div0_q, div0_d;
    logic                busy_q, busy_d;
    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    alu_result_q, alu_result_d;
    logic                zero_q, zero_d;
    logic [WIDTH-1:0]    branch_target_q, branch_target_d;
    logic [WIDTH-1:0]    store_data_q, store_data_d;
    logic [REG_BITS-1:0] dest_reg_q, dest_reg_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;

    logic [WIDTH-1:0] op_b_c, alu_res_c;
    logic [4:0]       shamt_c;
    logic             is_md_c, signed_c, a_neg_c, b_neg_c, accept_c;
    logic [WIDTH-1:0] a_mag_c, b_mag_c;
    logic [WIDTH:0]   mul_sum_c, div_shift_c, div_diff_c;
    logic [DW-1:0]    mul_next_c, div_next_c, prod_c;
    logic [WIDTH-1:0] quot_c, rem_c, md_hi_c, md_lo_c;

    // Single-cycle ALU; mfhi/mflo read the HI/LO value current at acceptance
    always_comb begin
        op_b_c    = alu_src ? immediate : read_data2;
        shamt_c   = immediate[10:6];
        alu_res_c = read_data1 + op_b_c;
        case (alu_op)
            3'b001: alu_res_c = read_data1 - op_b_c;
            3'b011: alu_res_c = read_data1 & op_b_c;
            3'b100: alu_res_c = read_data1 | op_b_c;
            3'b101: alu_res_c = WIDTH'($signed(read_data1) < $signed(op_b_c));
            3'b010: begin
                case (funct)
                    6'h22, 6'h23: alu_res_c = read_data1 - op_b_c;
                    6'h24:        alu_res_c = read_data1 & op_b_c;
                    6'h25:        alu_res_c = read_data1 | op_b_c;
                    6'h26:        alu_res_c = read_data1 ^ op_b_c;
                    6'h27:        alu_res_c = ~(read_data1 | op_b_c);
                    6'h2A:        alu_res_c = WIDTH'($signed(read_data1) < $signed(op_b_c));
                    6'h2B:        alu_res_c = WIDTH'(read_data1 < op_b_c);
                    6'h00:        alu_res_c = op_b_c << shamt_c;
                    6'h02:        alu_res_c = op_b_c >> shamt_c;
                    6'h03:        alu_res_c = WIDTH'($signed(op_b_c) >>> shamt_c);
                    6'h10:        alu_res_c = hi_q;
                    6'h12:        alu_res_c = lo_q;
                    default:      ;
                endcase
            end
            default: ;
        endcase
    end

    // Mult/div decode and operand magnitudes for the signed variants
    always_comb begin
        is_md_c  = MULDIV_EN && (alu_op == 3'b010) && (funct[5:2] == 4'b0110);
        signed_c = ~funct[0];
        a_neg_c  = signed_c & read_data1[WIDTH-1];
        b_neg_c  = signed_c & read_data2[WIDTH-1];
        a_mag_c  = a_neg_c ? -read_data1 : read_data1;
        b_mag_c  = b_neg_c ? -read_data2 : read_data2;
    end

    // One shift-add or restoring-subtract step, plus sign fix-up of the final step
    always_comb begin
        mul_sum_c   = {1'b0, acc_q[DW-1:WIDTH]} + {1'b0, opnd_q & {WIDTH{acc_q[0]}}};
        mul_next_c  = {mul_sum_c, acc_q[WIDTH-1:1]};
        div_shift_c = acc_q[DW-1:WIDTH-1];
        div_diff_c  = div_shift_c - {1'b0, opnd_q};
        // Remainder stays below the divisor, so the borrow bit alone decides the step
        div_next_c  = div_diff_c[WIDTH] ? {div_shift_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                        : {div_diff_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        prod_c      = neg_lo_q ? -mul_next_c : mul_next_c;
        quot_c      = div_next_c[WIDTH-1:0];
        rem_c       = div_next_c[DW-1:WIDTH];
        if (is_div_q) begin
            md_lo_c = div0_q ? {WIDTH{1'b1}} : (neg_lo_q ? -quot_c : quot_c);
            md_hi_c = neg_hi_q ? -rem_c : rem_c;
        end else begin
            md_lo_c = prod_c[WIDTH-1:0];
            md_hi_c = prod_c[DW-1:WIDTH];
        end
    end

    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept_c = in_valid && in_ready;

    // Next-state: FSM, mult/div datapath and EX/MEM output register
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        acc_d           = acc_q;
        opnd_d          = opnd_q;
        is_div_d        = is_div_q;
        neg_lo_d        = neg_lo_q;
        neg_hi_d        = neg_hi_q;
        div0_d          = div0_q;
        busy_d          = busy_q;
        out_valid_d     = out_valid_q;
        alu_result_d    = alu_result_q;
        zero_d          = zero_q;
        branch_target_d = branch_target_q;
        store_data_d    = store_data_q;
        dest_reg_d      = dest_reg_q;
        hi_d            = hi_q;
        lo_d            = lo_q;
        if (state_q == S_MULDIV) begin
            acc_d = is_div_q ? div_next_c : mul_next_c;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d      = S_IDLE;
                busy_d       = 1'b0;
                hi_d         = md_hi_c;
                lo_d         = md_lo_c;
                out_valid_d  = 1'b1;
                alu_result_d = '0;
                zero_d       = 1'b1;
            end
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (accept_c) begin
                branch_target_d = last_pc + (immediate << 2);
                store_data_d    = read_data2;
                dest_reg_d      = reg_dst ? rd : rt;
                if (is_md_c) begin
                    state_d     = S_MULDIV;
                    busy_d      = 1'b1;
                    cnt_d       = CNT_W'(WIDTH);
                    is_div_d    = funct[1];
                    acc_d       = {WIDTH'(0), (funct[1] ? a_mag_c : b_mag_c)};
                    opnd_d      = funct[1] ? b_mag_c : a_mag_c;
                    neg_lo_d    = a_neg_c ^ b_neg_c;
                    neg_hi_d    = a_neg_c;
                    div0_d      = (read_data2 == '0);
                    out_valid_d = 1'b0;
                end else begin
                    alu_result_d = alu_res_c;
                    zero_d       = (alu_res_c == '0);
                    out_valid_d  = 1'b1;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            acc_q           <= '0;
            opnd_q          <= '0;
            is_div_q        <= 1'b0;
            neg_lo_q        <= 1'b0;
            neg_hi_q        <= 1'b0;
            div0_q          <= 1'b0;
            busy_q          <= 1'b0;
            out_valid_q     <= 1'b0;
            alu_result_q    <= '0;
            zero_q          <= 1'b1;
            branch_target_q <= '0;
            store_data_q    <= '0;
            dest_reg_q      <= '0;
            hi_q            <= '0;
            lo_q            <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            acc_q           <= acc_d;
            opnd_q          <= opnd_d;
            is_div_q        <= is_div_d;
            neg_lo_q        <= neg_lo_d;
            neg_hi_q        <= neg_hi_d;
            div0_q          <= div0_d;
            busy_q          <= busy_d;
            out_valid_q     <= out_valid_d;
            alu_result_q    <= alu_result_d;
            zero_q          <= zero_d;
            branch_target_q <= branch_target_d;
            store_data_q    <= store_data_d;
            dest_reg_q      <= dest_reg_d;
            hi_q            <= hi_d;
            lo_q            <= lo_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign alu_result    = alu_result_q;
    assign zero          = zero_q;
    assign branch_target = branch_target_q;
    assign store_data    = store_data_q;
    assign dest_reg      = dest_reg_q;
    assign hi            = hi_q;
    assign lo            = lo_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_execute_stage_mc.sv
// Bench for execute_stage_mc: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model.
module tb_execute_stage_mc;
    localparam int unsigned W  = 32;
    localparam int unsigned RB = 5;

    logic          clk, rst_n, in_valid, in_ready, alu_src, reg_dst;
    logic          out_valid, out_ready, zero, busy;
    logic [W-1:0]  read_data1, read_data2, immediate, last_pc;
    logic [W-1:0]  alu_result, branch_target, store_data, hi, lo;
    logic [5:0]    funct;
    logic [2:0]    alu_op;
    logic [RB-1:0] rt, rd, dest_reg;

    int errors = 0;
    int checks = 0;

    execute_stage_mc #(.WIDTH(W), .REG_BITS(RB), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .read_data1(read_data1), .read_data2(read_data2), .immediate(immediate),
        .funct(funct), .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst),
        .last_pc(last_pc), .rt(rt), .rd(rd), .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .zero(zero), .branch_target(branch_target),
        .store_data(store_data), .dest_reg(dest_reg), .hi(hi), .lo(lo), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU result straight from the instruction semantics
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [5:0] f,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] sh, input logic [31:0] h,
                                            input logic [31:0] l);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: return a - b;
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd2: begin
                case (f)
                    6'h22, 6'h23: return a - b;
                    6'h24: return a & b;
                    6'h25: return a | b;
                    6'h26: return a ^ b;
                    6'h27: return ~(a | b);
                    6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
                    6'h2B: return (a < b) ? 32'd1 : 32'd0;
                    6'h00: return b << sh;
                    6'h02: return b >> sh;
                    6'h03: return 32'(sb >>> sh);
                    6'h10: return h;
                    6'h12: return l;
                    default: return a + b;
                endcase
            end
            default: return a + b;
        endcase
    endfunction

    // Reference {hi, lo} from 64-bit integer arithmetic
    function automatic logic [63:0] ref_muldiv(input logic [5:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f[1:0])
            2'b00: p = 64'(sa * sb);
            2'b01: p = ua * ub;
            2'b10: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {32'(r), 32'(q)};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    p = {ur[31:0], uq[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    // Transaction-level model state
    int            m_cnt;
    logic          m_ov, m_zero;
    logic [W-1:0]  m_res, m_bt, m_sd, m_hi, m_lo, m_phi, m_plo;
    logic [RB-1:0] m_dr;
    logic          m_acc, m_is_md;
    logic [W-1:0]  m_v;
    logic [63:0]   m_md;

    always_comb begin
        m_is_md = (alu_op == 3'd2) && (funct >= 6'h18) && (funct <= 6'h1B);
        m_acc   = (m_cnt == 0) && in_valid && (!m_ov || out_ready);
        m_v     = ref_alu(alu_op, funct, read_data1, alu_src ? immediate : read_data2,
                          immediate[10:6], m_hi, m_lo);
        m_md    = ref_muldiv(funct, read_data1, read_data2);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;  m_ov <= 1'b0; m_zero <= 1'b1; m_res <= '0;
            m_bt <= '0;  m_sd <= '0;   m_dr <= '0;     m_hi <= '0;
            m_lo <= '0;  m_phi <= '0;  m_plo <= '0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_hi <= m_phi; m_lo <= m_plo; m_ov <= 1'b1; m_res <= '0; m_zero <= 1'b1;
            end
        end else begin
            if (m_ov && out_ready) m_ov <= 1'b0;
            if (m_acc) begin
                m_bt <= last_pc + (immediate << 2);
                m_sd <= read_data2;
                m_dr <= reg_dst ? rd : rt;
                if (m_is_md) begin
                    m_phi <= m_md[63:32];
                    m_plo <= m_md[31:0];
                    m_cnt <= W;
                    m_ov  <= 1'b0;
                end else begin
                    m_res  <= m_v;
                    m_zero <= (m_v == '0);
                    m_ov   <= 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("out_valid", 64'(out_valid), 64'(m_ov));
            chk("busy", 64'(busy), 64'(m_cnt != 0));
            chk("in_ready", 64'(in_ready), 64'((m_cnt == 0) && (!m_ov || out_ready)));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
            if (m_ov) begin
                chk("alu_result", 64'(alu_result), 64'(m_res));
                chk("zero", 64'(zero), 64'(m_zero));
                chk("branch_target", 64'(branch_target), 64'(m_bt));
                chk("store_data", 64'(store_data), 64'(m_sd));
                chk("dest_reg", 64'(dest_reg), 64'(m_dr));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] im, input logic src);
        alu_op = op; funct = f; read_data1 = a; read_data2 = b; immediate = im; alu_src = src;
    endtask

    // Issue one mult/div, check its latency and resulting HI/LO
    task automatic run_md(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        int bad;
        set_op(3'd2, f, a, b, 32'd0, 1'b0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 1;
        bad = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
            step();
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'd33);
        chk({name, "_stall"}, 64'(bad), 64'd0);
        chk({name, "_hi"}, 64'(hi), 64'(ehi));
        chk({name, "_lo"}, 64'(lo), 64'(elo));
        chk({name, "_result"}, 64'(alu_result), 64'd0);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'($urandom_range(0, 15));
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [5:0] pick_funct();
        int k;
        k = $urandom_range(0, 19);
        case (k)
            0, 1, 2: return 6'h18 + 6'(k);
            3:  return 6'h1B;
            4:  return 6'h10;
            5:  return 6'h12;
            6:  return 6'h00;
            7:  return 6'h02;
            8:  return 6'h03;
            9:  return 6'h20;
            10: return 6'h22;
            11: return 6'h24;
            12: return 6'h25;
            13: return 6'h26;
            14: return 6'h27;
            15: return 6'h2A;
            16: return 6'h2B;
            17: return 6'h21;
            18: return 6'h23;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; reg_dst = 1'b0;
        last_pc = 32'd0; rt = 5'd0; rd = 5'd0;
        set_op(3'd0, 6'h20, 32'd0, 32'd0, 32'd0, 1'b0);
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_zero", 64'(zero), 64'd1);
        chk("rst_alu_result", 64'(alu_result), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_branch_target", 64'(branch_target), 64'd0);
        chk("rst_dest_reg", 64'(dest_reg), 64'd0);
        rst_n = 1'b1;
        step();

        // sub 5-5, then addi 0x1000 + (-4)
        set_op(3'd2, 6'h22, 32'd5, 32'd5, 32'd0, 1'b0);
        in_valid = 1'b1;
        step();
        chk("sub_result", 64'(alu_result), 64'd0);
        chk("sub_zero", 64'(zero), 64'd1);
        chk("sub_valid", 64'(out_valid), 64'd1);
        set_op(3'd0, 6'h00, 32'h0000_1000, 32'd0, 32'hFFFF_FFFC, 1'b1);
        step();
        chk("addi_result", 64'(alu_result), 64'h0000_0FFC);
        chk("addi_zero", 64'(zero), 64'd0);

        // Four back-to-back adds, then a blocked output for three cycles
        for (int i = 1; i <= 4; i++) begin
            set_op(3'd0, 6'h00, 32'(i), 32'(10 * i), 32'd0, 1'b0);
            step();
            chk("b2b_result", 64'(alu_result), 64'(11 * i));
            chk("b2b_valid", 64'(out_valid), 64'd1);
        end
        set_op(3'd0, 6'h00, 32'd100, 32'd1, 32'd0, 1'b0);
        out_ready = 1'b0;
        #1;
        chk("hold_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_result", 64'(alu_result), 64'd44);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        step();
        chk("release_result", 64'(alu_result), 64'd101);
        in_valid = 1'b0;
        step();

        // Multiply/divide with HI/LO forwarding to mflo
        run_md("mult", 6'h18, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        set_op(3'd2, 6'h12, 32'd0, 32'd0, 32'd0, 1'b0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("mflo_result", 64'(alu_result), 64'hFFFF_FFFA);
        run_md("div", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu0", 6'h1B, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);

        // Shifts, branch target, destination select
        in_valid = 1'b1;
        set_op(3'd2, 6'h03, 32'd0, 32'h8000_0000, 32'(4 << 6), 1'b0);
        step();
        chk("sra_result", 64'(alu_result), 64'hF800_0000);
        set_op(3'd2, 6'h00, 32'd0, 32'd1, 32'(31 << 6), 1'b0);
        step();
        chk("sll_result", 64'(alu_result), 64'h8000_0000);
        set_op(3'd0, 6'h00, 32'd16, 32'h0000_CAFE, 32'hFFFF_FFFF, 1'b1);
        last_pc = 32'h0000_0100; reg_dst = 1'b1; rt = 5'd3; rd = 5'd17;
        step();
        chk("bt_target", 64'(branch_target), 64'h0000_00FC);
        chk("bt_dest_reg", 64'(dest_reg), 64'd17);
        chk("bt_store_data", 64'(store_data), 64'h0000_CAFE);
        chk("bt_result", 64'(alu_result), 64'd15);
        in_valid = 1'b0;
        step();

        // Reset in the middle of a multiply
        set_op(3'd2, 6'h19, 32'd5, 32'd7, 32'd0, 1'b0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("mid_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 3) != 0);
            alu_op     = ($urandom_range(0, 1) != 0) ? 3'd2 : 3'($urandom_range(0, 7));
            funct      = pick_funct();
            read_data1 = rand_word();
            read_data2 = rand_word();
            immediate  = ($urandom_range(0, 1) != 0) ? rand_word() : 32'($signed(16'($urandom)));
            alu_src    = 1'($urandom);
            reg_dst    = 1'($urandom);
            last_pc    = $urandom & 32'hFFFF_FFFC;
            rt         = 5'($urandom);
            rd         = 5'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
